pixel_event_history: RTL and testbench

Per-pixel event history store for the graph-construction front end: keeps the last DEPTH events of every sensor pixel in DEPTH parallel UltraRAM banks plus a per-pixel fill counter. Under a request/response handshake it serves three operations:

- read a pixel's history;
- insert a new event (shift-in, oldest dropped);
- clear a pixel.

It is the parametrised successor of the single-shot global event buffer. It adds a sequenced read-modify-write, occupancy tracking, post-reset counter initialisation and out-of-range protection.

---
 rtl/pixel_event_history_if.sv | 30 +++
 rtl/pixel_event_history.sv | 195 +++++++++++++++++++
 tb/tb_pixel_event_history.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_event_history_if.sv
// Request/response port of the per-pixel event history store.
// The master side issues requests and consumes responses; the slave side serves them.
interface pixel_event_history_if #(
  parameter int PIX_W   = 14,
  parameter int EVENT_W = 64,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 5
) ();
  logic                     req_valid;
  logic                     req_ready;
  logic [1:0]               req_op;
  logic [PIX_W-1:0]         req_pixel;
  logic [EVENT_W-1:0]       req_event;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [DEPTH*EVENT_W-1:0] rsp_hist;
  logic [CNT_W-1:0]         rsp_count;
  logic [PIX_W-1:0]         rsp_pixel;
  logic                     rsp_err;

  modport master (
    output req_valid, req_op, req_pixel, req_event, rsp_ready,
    input  req_ready, rsp_valid, rsp_hist, rsp_count, rsp_pixel, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_pixel, req_event, rsp_ready,
    output req_ready, rsp_valid, rsp_hist, rsp_count, rsp_pixel, rsp_err
  );
endinterface

// File: rtl/pixel_event_history.sv
// Per-pixel event history: DEPTH shift-in banks plus a fill counter per pixel,
// served as read / insert / clear through a sequenced read-modify-write.
module pixel_event_history #(
  parameter int TOT_PIXEL = 12000,
  parameter int EVENT_W   = 64,
  parameter int DEPTH     = 16,
  parameter int PIX_W     = $clog2(TOT_PIXEL),
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  pixel_event_history_if.slave bus,
  output logic busy
);
  localparam int AW = (TOT_PIXEL > 1) ? $clog2(TOT_PIXEL) : 1;
  localparam logic [PIX_W:0]   TOT_P    = (PIX_W + 1)'(TOT_PIXEL);
  localparam logic [AW-1:0]    LAST_IDX = AW'(TOT_PIXEL - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [1:0]       OP_INSERT = 2'b01;
  localparam logic [1:0]       OP_CLEAR  = 2'b10;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_WB, S_RESP} state_t;

  state_t                   state_q, state_d;
  logic [AW-1:0]            init_idx_q, init_idx_d;
  logic [1:0]               op_q, op_d;
  logic [PIX_W-1:0]         pix_q, pix_d;
  logic [EVENT_W-1:0]       ev_q, ev_d;
  logic                     err_q, err_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [DEPTH*EVENT_W-1:0] rsp_hist_q, rsp_hist_d;
  logic [CNT_W-1:0]         rsp_count_q, rsp_count_d;
  logic [PIX_W-1:0]         rsp_pixel_q, rsp_pixel_d;
  logic                     rsp_err_q, rsp_err_d;

  logic [AW-1:0]            mem_addr_s;
  logic                     bank_we_s;
  logic                     cnt_we_s;
  logic [CNT_W-1:0]         cnt_wdata_s;
  logic [CNT_W-1:0]         cnt_eff_s;
  logic [CNT_W-1:0]         rd_cnt_q;
  logic [DEPTH*EVENT_W-1:0] rd_hist_s;
  logic [CNT_W-1:0]         cnt_mem [TOT_PIXEL];

  assign bus.req_ready = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_hist  = rsp_hist_q;
  assign bus.rsp_count = rsp_count_q;
  assign bus.rsp_pixel = rsp_pixel_q;
  assign bus.rsp_err   = rsp_err_q;

  // Banks: bank 0 takes the new event, bank i takes the old slot i-1 on insert.
  for (genvar b = 0; b < DEPTH; b++) begin : g_bank
    (* ram_style = "ultra" *) logic [EVENT_W-1:0] bank_mem [TOT_PIXEL];
    logic [EVENT_W-1:0] rd_q;
    logic [EVENT_W-1:0] wdata_s;
    if (b == 0) begin : g_head
      assign wdata_s = ev_q;
    end else begin : g_shift
      assign wdata_s = rd_hist_s[(b-1)*EVENT_W +: EVENT_W];
    end
    assign rd_hist_s[b*EVENT_W +: EVENT_W] = rd_q;

    // Single-port bank: registered read in RD, write in WB.
    always_ff @(posedge clk) begin
      if (bank_we_s) begin
        bank_mem[mem_addr_s] <= wdata_s;
      end
      if (state_q == S_RD) begin
        rd_q <= bank_mem[mem_addr_s];
      end
    end
  end

  // Fill-count array: swept to zero during INIT, updated in WB.
  always_ff @(posedge clk) begin
    if (cnt_we_s) begin
      cnt_mem[mem_addr_s] <= cnt_wdata_s;
    end
    if (state_q == S_RD) begin
      rd_cnt_q <= cnt_mem[mem_addr_s];
    end
  end

  // Next-state, memory control and response loading.
  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    op_d        = op_q;
    pix_d       = pix_q;
    ev_d        = ev_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    rsp_hist_d  = rsp_hist_q;
    rsp_count_d = rsp_count_q;
    rsp_pixel_d = rsp_pixel_q;
    rsp_err_d   = rsp_err_q;
    mem_addr_s  = err_q ? '0 : pix_q[AW-1:0];
    bank_we_s   = 1'b0;
    cnt_we_s    = 1'b0;
    cnt_wdata_s = '0;
    cnt_eff_s   = err_q ? '0 : rd_cnt_q;

    case (state_q)
      S_INIT: begin
        mem_addr_s = init_idx_q;
        cnt_we_s   = 1'b1;
        if (init_idx_q == LAST_IDX) begin
          init_idx_d = '0;
          state_d    = S_IDLE;
        end else begin
          init_idx_d = init_idx_q + AW'(1);
        end
      end
      S_IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          pix_d   = bus.req_pixel;
          ev_d    = bus.req_event;
          err_d   = ({1'b0, bus.req_pixel} >= TOT_P);
          state_d = S_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        state_d = S_WB;
      end
      S_WB: begin
        if (err_q) begin
          cnt_we_s = 1'b0;
        end else if (op_q == OP_INSERT) begin
          bank_we_s   = 1'b1;
          cnt_we_s    = 1'b1;
          cnt_wdata_s = (rd_cnt_q >= DEPTH_C) ? DEPTH_C : rd_cnt_q + CNT_W'(1);
        end else if (op_q == OP_CLEAR) begin
          cnt_we_s = 1'b1;
        end else begin
          cnt_we_s = 1'b0;
        end
        // Slots at or beyond the fill count may hold stale events; never expose them.
        for (int i = 0; i < DEPTH; i++) begin
          rsp_hist_d[i*EVENT_W +: EVENT_W] = (CNT_W'(i) < cnt_eff_s) ?
                                             rd_hist_s[i*EVENT_W +: EVENT_W] : '0;
        end
        rsp_count_d = cnt_eff_s;
        rsp_pixel_d = pix_q;
        rsp_err_d   = err_q;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // Control and response registers; reset restarts the count sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      init_idx_q  <= '0;
      op_q        <= 2'b00;
      pix_q       <= '0;
      ev_q        <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_hist_q  <= '0;
      rsp_count_q <= '0;
      rsp_pixel_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      op_q        <= op_d;
      pix_q       <= pix_d;
      ev_q        <= ev_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hist_q  <= rsp_hist_d;
      rsp_count_q <= rsp_count_d;
      rsp_pixel_q <= rsp_pixel_d;
      rsp_err_q   <= rsp_err_d;
    end
  end
endmodule

// File: tb/tb_pixel_event_history.sv
// Self-checking bench: table of requests with expected responses fed through a
// scoreboard queue, plus hand-written latency, hold and mid-operation reset sequences.
module tb_pixel_event_history;
  localparam int TP = 16;
  localparam int DP = 4;
  localparam int EW = 16;
  localparam int PW = 5;
  localparam int CW = 3;
  localparam int HW = DP * EW;

  typedef struct {
    logic [1:0]    op;
    logic [PW-1:0] pix;
    logic [EW-1:0] ev;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hist;
    logic          err;
  } vec_t;

  typedef struct {
    logic [CW-1:0] cnt;
    logic [HW-1:0] hist;
    logic          err;
    logic [PW-1:0] pix;
  } exp_t;

  logic clk;
  logic rst;
  logic busy;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t tbl[$];
  exp_t sb_q[$];
  exp_t mon_e;
  logic [HW-1:0] hold_hist;
  logic [CW-1:0] hold_cnt;

  pixel_event_history_if #(.PIX_W(PW), .EVENT_W(EW), .DEPTH(DP), .CNT_W(CW)) bus ();

  pixel_event_history #(
    .TOT_PIXEL(TP), .EVENT_W(EW), .DEPTH(DP), .PIX_W(PW), .CNT_W(CW)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] op, input logic [PW-1:0] pix, input logic [EW-1:0] ev,
                     input logic [CW-1:0] cnt, input logic [HW-1:0] hist, input logic err);
    vec_t v;
    v.op = op; v.pix = pix; v.ev = ev; v.cnt = cnt; v.hist = hist; v.err = err;
    tbl.push_back(v);
  endtask

  task automatic push_exp(input logic [CW-1:0] cnt, input logic [HW-1:0] hist,
                          input logic err, input logic [PW-1:0] pix);
    exp_t e;
    e.cnt = cnt; e.hist = hist; e.err = err; e.pix = pix;
    sb_q.push_back(e);
  endtask

  // Drives a request right after a rising edge and returns once it is accepted.
  task automatic drive_req(input logic [1:0] op, input logic [PW-1:0] pix,
                           input logic [EW-1:0] ev, output bit acc);
    acc = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_pixel = pix;
    bus.req_event = ev;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      if (bus.req_ready) acc = 1'b1;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("req_accept", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && sb_q.size() != 0; t++) @(negedge clk);
    check("rsp_timeout_pending", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
  endtask

  task automatic wait_ready(input string name);
    bit ok = 1'b0;
    for (int t = 0; t < 60 && !ok; t++) begin
      @(negedge clk);
      if (bus.req_ready) ok = 1'b1;
    end
    check(name, 64'(ok), 64'd1);
  endtask

  task automatic send(input vec_t v);
    bit acc;
    push_exp(v.cnt, v.hist, v.err, v.pix);
    drive_req(v.op, v.pix, v.ev, acc);
    drain();
  endtask

  // Scoreboard: compare each response in the cycle its handshake completes.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_rsp: got response for pixel %0d, expected none", bus.rsp_pixel);
      end else begin
        mon_e = sb_q.pop_front();
        check($sformatf("rsp_count_pix%0d", mon_e.pix), 64'(bus.rsp_count), 64'(mon_e.cnt));
        check($sformatf("rsp_hist_pix%0d", mon_e.pix), 64'(bus.rsp_hist), 64'(mon_e.hist));
        check($sformatf("rsp_err_pix%0d", mon_e.pix), 64'(bus.rsp_err), 64'(mon_e.err));
        check("rsp_pixel", 64'(bus.rsp_pixel), 64'(mon_e.pix));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_pixel = '0;
    bus.req_event = '0;
    bus.rsp_ready = 1'b1;

    // Reset values and INIT duration.
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_hist", 64'(bus.rsp_hist), 64'd0);
    check("rst_rsp_count", 64'(bus.rsp_count), 64'd0);
    check("rst_rsp_pixel", 64'(bus.rsp_pixel), 64'd0);
    check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("init_ready_c0", 64'(bus.req_ready), 64'd0);
    for (int k = 1; k <= TP; k++) begin
      @(posedge clk); #1;
      check($sformatf("init_ready_c%0d", k), 64'(bus.req_ready), (k < TP) ? 64'd0 : 64'd1);
    end

    // Request table: op, pixel, event, expected pre-op count, history, err.
    add(2'b00, 5'd7,  16'h0000, 3'd0, 64'h0, 1'b0);
    add(2'b01, 5'd3,  16'h000A, 3'd0, 64'h0, 1'b0);
    add(2'b01, 5'd3,  16'h000B, 3'd1, 64'h0000_0000_0000_000A, 1'b0);
    add(2'b01, 5'd3,  16'h000C, 3'd2, 64'h0000_0000_000A_000B, 1'b0);
    add(2'b00, 5'd3,  16'h0000, 3'd3, 64'h0000_000A_000B_000C, 1'b0);
    add(2'b01, 5'd5,  16'h0001, 3'd0, 64'h0, 1'b0);
    add(2'b01, 5'd5,  16'h0002, 3'd1, 64'h0000_0000_0000_0001, 1'b0);
    add(2'b01, 5'd5,  16'h0003, 3'd2, 64'h0000_0000_0001_0002, 1'b0);
    add(2'b01, 5'd5,  16'h0004, 3'd3, 64'h0000_0001_0002_0003, 1'b0);
    add(2'b01, 5'd5,  16'h0005, 3'd4, 64'h0001_0002_0003_0004, 1'b0);
    add(2'b01, 5'd5,  16'h0006, 3'd4, 64'h0002_0003_0004_0005, 1'b0);
    add(2'b00, 5'd5,  16'h0000, 3'd4, 64'h0003_0004_0005_0006, 1'b0);
    add(2'b01, 5'd2,  16'h0021, 3'd0, 64'h0, 1'b0);
    add(2'b01, 5'd2,  16'h0022, 3'd1, 64'h0000_0000_0000_0021, 1'b0);
    add(2'b01, 5'd9,  16'h0091, 3'd0, 64'h0, 1'b0);
    add(2'b01, 5'd9,  16'h0092, 3'd1, 64'h0000_0000_0000_0091, 1'b0);
    add(2'b01, 5'd9,  16'h0093, 3'd2, 64'h0000_0000_0091_0092, 1'b0);
    add(2'b10, 5'd2,  16'h0000, 3'd2, 64'h0000_0000_0021_0022, 1'b0);
    add(2'b00, 5'd2,  16'h0000, 3'd0, 64'h0, 1'b0);
    add(2'b00, 5'd9,  16'h0000, 3'd3, 64'h0000_0091_0092_0093, 1'b0);
    add(2'b11, 5'd9,  16'h0000, 3'd3, 64'h0000_0091_0092_0093, 1'b0);
    add(2'b01, 5'd2,  16'h002A, 3'd0, 64'h0, 1'b0);
    add(2'b00, 5'd2,  16'h0000, 3'd1, 64'h0000_0000_0000_002A, 1'b0);
    add(2'b01, 5'd20, 16'h00EE, 3'd0, 64'h0, 1'b1);
    add(2'b10, 5'd16, 16'h0000, 3'd0, 64'h0, 1'b1);
    add(2'b00, 5'd20, 16'h0000, 3'd0, 64'h0, 1'b1);
    add(2'b01, 5'd15, 16'h000F, 3'd0, 64'h0, 1'b0);
    add(2'b00, 5'd15, 16'h0000, 3'd1, 64'h0000_0000_0000_000F, 1'b0);
    add(2'b00, 5'd4,  16'h0000, 3'd0, 64'h0, 1'b0);
    add(2'b00, 5'd0,  16'h0000, 3'd0, 64'h0, 1'b0);
    add(2'b00, 5'd3,  16'h0000, 3'd3, 64'h0000_000A_000B_000C, 1'b0);
    add(2'b00, 5'd5,  16'h0000, 3'd4, 64'h0003_0004_0005_0006, 1'b0);
    for (int i = 0; i < tbl.size(); i++) send(tbl[i]);

    // Latency, stalled response and one-cycle re-accept.
    bus.rsp_ready = 1'b0;
    push_exp(3'd3, 64'h0000_000A_000B_000C, 1'b0, 5'd3);
    drive_req(2'b00, 5'd3, 16'h0000, acc);
    @(negedge clk); check("lat_rd_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk); check("lat_wb_valid", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk); check("lat_t3_valid", 64'(bus.rsp_valid), 64'd1);
    hold_hist = bus.rsp_hist;
    hold_cnt  = bus.rsp_count;
    check("lat_t3_count", 64'(hold_cnt), 64'd3);
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    bus.req_pixel = 5'd9;
    push_exp(3'd3, 64'h0000_0091_0092_0093, 1'b0, 5'd9);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", 64'(bus.rsp_valid), 64'd1);
      check("hold_req_ready", 64'(bus.req_ready), 64'd0);
      check("hold_hist", 64'(bus.rsp_hist), 64'(hold_hist));
      check("hold_count", 64'(bus.rsp_count), 64'(hold_cnt));
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    check("release_req_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    check("release_accept_busy", 64'(busy), 64'd1);
    bus.req_valid = 1'b0;
    drain();

    // Reset while a response is pending drops rsp_valid at once.
    bus.rsp_ready = 1'b0;
    drive_req(2'b00, 5'd5, 16'h0000, acc);
    repeat (3) @(negedge clk);
    check("resp_pending_valid", 64'(bus.rsp_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_resp_valid_async", 64'(bus.rsp_valid), 64'd0);
    check("rst_resp_busy", 64'(busy), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_ready("reinit_after_resp");

    // Reset during WB of an insert to pixel 1.
    drive_req(2'b01, 5'd1, 16'h0077, acc);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_wb_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_wb_req_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_ready("reinit_after_wb");
    add(2'b00, 5'd1, 16'h0000, 3'd0, 64'h0, 1'b0);
    add(2'b00, 5'd3, 16'h0000, 3'd0, 64'h0, 1'b0);
    add(2'b01, 5'd1, 16'h0055, 3'd0, 64'h0, 1'b0);
    add(2'b00, 5'd1, 16'h0000, 3'd1, 64'h0000_0000_0000_0055, 1'b0);
    for (int i = tbl.size() - 4; i < tbl.size(); i++) send(tbl[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
